// File: rtl/rob_pkg.sv
// Shared constants and types for the ROB allocation/retirement controller.
// Optional build macro: ROB_CDB_BYPASS_EN (CDB-to-commit bypass on the head entry).
package rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int TAG_W     = 6;
  localparam int REG_W     = 6;
  localparam int DATA_W    = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    reg_t  rd;
    data_t data;
  } rob_entry_t;

  typedef struct packed {
    reg_t  rd;
    tag_t  tag;
    data_t data;
  } commit_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping TAG_W-bit ring pointer; clear dominates increment.
import rob_pkg::*;

module rob_ptr (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [TAG_W-1:0] ptr
);

  logic [TAG_W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/rob_alloc_ctrl.sv
// In-order ROB tag allocation, CDB writeback capture and one-per-cycle retirement.
// Define ROB_CDB_BYPASS_EN to let a CDB result for the head tag retire on the same edge.
import rob_pkg::*;

module rob_alloc_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic              dc_valid,
  input  logic [REG_W-1:0]  dc_rd,
  output logic              dc_ready,
  output logic [TAG_W-1:0]  rob_free_entry,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              cm_valid,
  output logic [REG_W-1:0]  cm_rd,
  output logic [TAG_W-1:0]  cm_tag,
  output logic [DATA_W-1:0] cm_data,
  output logic [TAG_W:0]    rob_count,
  output logic              rob_empty
);

  tag_t           head;
  tag_t           tail;
  logic [TAG_W:0] count_reg;
  rob_entry_t     entry_q [ROB_DEPTH];
  rob_entry_t     head_entry;
  logic           alloc_fire;
  logic           commit_fire;
  logic           bypass_hit;
  data_t          commit_data;
  logic           cm_valid_reg;
  commit_t        cm_reg;

  assign dc_ready   = (count_reg != (TAG_W+1)'(ROB_DEPTH)) & ~flush;
  assign alloc_fire = dc_valid & dc_ready;
  assign head_entry = entry_q[head];

`ifdef ROB_CDB_BYPASS_EN
  assign bypass_hit = cdb_valid & (cdb_tag == head) & head_entry.valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // flush suppresses retirement on the same edge
  assign commit_fire = ~flush & head_entry.valid & (head_entry.done | bypass_hit);
  assign commit_data = bypass_hit ? cdb_data : head_entry.data;

  rob_ptr u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_fire),
    .clr   (flush),
    .ptr   (head)
  );

  rob_ptr u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc_fire),
    .clr   (flush),
    .ptr   (tail)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      rob_entry_t entry_reg;

      // allocation only ever targets an invalid slot, so it never races a writeback or commit
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (flush) begin
          entry_reg.valid <= 1'b0;
        end else if (alloc_fire && (tail == tag_t'(gi))) begin
          entry_reg.valid <= 1'b1;
          entry_reg.done  <= 1'b0;
          entry_reg.rd    <= dc_rd;
          entry_reg.data  <= '0;
        end else begin
          if (cdb_valid && (cdb_tag == tag_t'(gi)) && entry_reg.valid) begin
            entry_reg.done <= 1'b1;
            entry_reg.data <= cdb_data;
          end
          if (commit_fire && (head == tag_t'(gi))) begin
            entry_reg.valid <= 1'b0;
          end
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_reg <= '0;
    end else begin
      case ({alloc_fire, commit_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // commit payload holds its last value between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      cm_valid_reg <= 1'b0;
      cm_reg       <= '0;
    end else if (flush) begin
      cm_valid_reg <= 1'b0;
    end else if (commit_fire) begin
      cm_valid_reg <= 1'b1;
      cm_reg.rd    <= head_entry.rd;
      cm_reg.tag   <= head;
      cm_reg.data  <= commit_data;
    end else begin
      cm_valid_reg <= 1'b0;
    end
  end

  assign rob_free_entry = tail;
  assign rob_count      = count_reg;
  assign rob_empty      = (count_reg == '0);
  assign cm_valid       = cm_valid_reg;
  assign cm_rd          = cm_reg.rd;
  assign cm_tag         = cm_reg.tag;
  assign cm_data        = cm_reg.data;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl: queue-level reference model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_rob_alloc_ctrl;

  logic        clk;
  logic        reset;
  logic        dc_valid;
  logic [5:0]  dc_rd;
  logic        dc_ready;
  logic [5:0]  rob_free_entry;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        cm_valid;
  logic [5:0]  cm_rd;
  logic [5:0]  cm_tag;
  logic [31:0] cm_data;
  logic [6:0]  rob_count;
  logic        rob_empty;

  int n_chk  = 0;
  int n_fail = 0;

  rob_alloc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .dc_valid       (dc_valid),
    .dc_rd          (dc_rd),
    .dc_ready       (dc_ready),
    .rob_free_entry (rob_free_entry),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .flush          (flush),
    .cm_valid       (cm_valid),
    .cm_rd          (cm_rd),
    .cm_tag         (cm_tag),
    .cm_data        (cm_data),
    .rob_count      (rob_count),
    .rob_empty      (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions as an ordered queue, oldest first.
  typedef struct {
    logic [5:0]  rd;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          head_m;
  bit          m_live = 0;
  bit          m_cm_valid;
  logic [5:0]  m_cm_rd;
  logic [5:0]  m_cm_tag;
  logic [31:0] m_cm_data;
  int          m_sz;
  int          m_idx;
  bit          m_byp;
  bit          m_commit;
  ent_t        m_new;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      head_m     = 0;
      m_cm_valid = 0;
      m_cm_rd    = 0;
      m_cm_tag   = 0;
      m_cm_data  = 0;
      m_live     = 1;
    end else if (m_live) begin
      if (flush) begin
        q.delete();
        head_m     = 0;
        m_cm_valid = 0;
      end else begin
        m_sz  = q.size();
        m_byp = 0;
`ifdef ROB_CDB_BYPASS_EN
        m_byp = cdb_valid && (m_sz > 0) && (int'(cdb_tag) == head_m);
`endif
        m_commit = (m_sz > 0) && (q[0].done || m_byp);
        if (m_commit) begin
          m_cm_valid = 1;
          m_cm_rd    = q[0].rd;
          m_cm_tag   = 6'(head_m);
          m_cm_data  = m_byp ? cdb_data : q[0].data;
        end else begin
          m_cm_valid = 0;
        end
        if (cdb_valid) begin
          m_idx = (int'(cdb_tag) - head_m + 64) % 64;
          if (m_idx < m_sz) begin
            q[m_idx].done = 1;
            q[m_idx].data = cdb_data;
          end
        end
        if (m_commit) begin
          void'(q.pop_front());
          head_m = (head_m + 1) % 64;
        end
        if (dc_valid && (m_sz < 64)) begin
          m_new.rd   = dc_rd;
          m_new.done = 0;
          m_new.data = 0;
          q.push_back(m_new);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("dc_ready", dc_ready, (q.size() != 64) && !flush);
      chk("rob_free_entry", rob_free_entry, (head_m + q.size()) % 64);
      chk("rob_count", rob_count, q.size());
      chk("rob_empty", rob_empty, q.size() == 0);
      chk("cm_valid", cm_valid, m_cm_valid);
      chk("cm_rd", cm_rd, m_cm_rd);
      chk("cm_tag", cm_tag, m_cm_tag);
      chk("cm_data", cm_data, m_cm_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_commit(input int start, output int n);
    n = start;
    while (!cm_valid && n < 6) begin
      tick();
      n++;
    end
    if (!cm_valid) chk("commit_timeout", 0, 1);
  endtask

  int lat;
  int exp_lat;

  initial begin
    reset = 1; dc_valid = 0; dc_rd = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_count", rob_count, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_cm_valid", cm_valid, 0);
    chk("rst_ready", dc_ready, 1);

    // dispatch rd 5,7,9
    dc_valid = 1; dc_rd = 6'd5;
    chk("free0", rob_free_entry, 0);
    tick(); chk("free1", rob_free_entry, 1);
    dc_rd = 6'd7;
    tick(); chk("free2", rob_free_entry, 2);
    dc_rd = 6'd9;
    tick(); dc_valid = 0;
    chk("count3", rob_count, 3);
    chk("no_commit_yet", cm_valid, 0);

    // out-of-order writebacks retire in order
    cdb_valid = 1; cdb_tag = 6'd1; cdb_data = 32'hAAAA;
    tick();
    cdb_tag = 6'd0; cdb_data = 32'h1234;
    tick();
    cdb_valid = 0;
    wait_commit(0, lat);
    chk("c0_rd", cm_rd, 5); chk("c0_tag", cm_tag, 0); chk("c0_data", cm_data, 32'h1234);
    tick();
    chk("c1_valid", cm_valid, 1); chk("c1_rd", cm_rd, 7);
    chk("c1_tag", cm_tag, 1); chk("c1_data", cm_data, 32'hAAAA);
    tick();
    chk("c2_none", cm_valid, 0); chk("count1", rob_count, 1);

    // drain, then writeback to an unallocated tag
    cdb_valid = 1; cdb_tag = 6'd2; cdb_data = 32'h22;
    tick(); cdb_valid = 0;
    wait_commit(1, lat);
    chk("c2_tag", cm_tag, 2);
    tick();
    chk("drained", rob_count, 0);
    cdb_valid = 1; cdb_tag = 6'd40; cdb_data = 32'hDEAD;
    tick(); cdb_valid = 0;
    chk("stray_cm", cm_valid, 0); chk("stray_count", rob_count, 0);
    chk("stray_hold", cm_data, 32'h22);
    tick(); chk("stray_cm2", cm_valid, 0);

    // flush with 10 in flight and same-cycle dispatch/CDB
    dc_valid = 1;
    for (int i = 0; i < 10; i++) begin
      dc_rd = 6'(i + 10);
      tick();
    end
    dc_valid = 0;
    chk("count10", rob_count, 10);
    cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'h5;
    tick();
    flush = 1; dc_valid = 1; cdb_tag = 6'd3; cdb_data = 32'h33;
    #1 chk("flush_ready", dc_ready, 0);
    tick();
    flush = 0; dc_valid = 0; cdb_valid = 0;
    #1;
    chk("fl_count", rob_count, 0); chk("fl_free", rob_free_entry, 0);
    chk("fl_empty", rob_empty, 1); chk("fl_cm", cm_valid, 0);
    cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 32'h99;
    tick(); cdb_valid = 0;
    tick();
    chk("late_cdb_cm", cm_valid, 0); chk("late_cdb_count", rob_count, 0);

    // fill to 64, hold a dispatch, free one slot
    dc_valid = 1;
    for (int i = 0; i < 64; i++) begin
      dc_rd = 6'(i);
      tick();
    end
    dc_rd = 6'd33;
    #1;
    chk("full_ready", dc_ready, 0); chk("full_count", rob_count, 64);
    chk("full_free", rob_free_entry, 0);
    cdb_valid = 1; cdb_tag = 6'd0; cdb_data = 32'h77;
    tick(); cdb_valid = 0;
    wait_commit(1, lat);
    chk("full_c_rd0", cm_rd, 0); chk("full_c_data", cm_data, 32'h77);
    chk("full_c_count", rob_count, 63); chk("full_c_ready", dc_ready, 1);
    chk("wrap_free", rob_free_entry, 0);
    tick(); dc_valid = 0;
    chk("refill_count", rob_count, 64); chk("refill_free", rob_free_entry, 1);

    // writeback-to-commit latency on the head entry (tag 1, rd 1)
`ifdef ROB_CDB_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    cdb_valid = 1; cdb_tag = 6'd1; cdb_data = 32'h55;
    tick(); cdb_valid = 0;
    wait_commit(1, lat);
    chk("latency", lat, exp_lat);
    chk("lat_data", cm_data, 32'h55); chk("lat_tag", cm_tag, 1); chk("lat_rd", cm_rd, 1);

    // reset mid-operation
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst2_count", rob_count, 0); chk("rst2_data", cm_data, 0);
    chk("rst2_rd", cm_rd, 0); chk("rst2_free", rob_free_entry, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
